// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with line refill over a single-beat read bus.
// Tag/data arrays read synchronously; valid bits live in flops so they reset.
module icache_dm #(
  parameter int    LINES          = 64,
  parameter int    WORDS_PER_LINE = 4,
  parameter string INIT_H         = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fe_req,
  input  logic [31:0] fe_addr,
  output logic        fe_ready,
  input  logic        fe_kill,
  output logic        fe_valid,
  output logic [31:0] fe_instr,
  output logic [31:0] fe_pc,
  output logic [31:0] mem_addr,
  output logic        mem_ren,
  input  logic [31:0] mem_rdata,
  input  logic        mem_done,
  input  logic        inv,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int OW = $clog2(WORDS_PER_LINE);
  localparam int IW = $clog2(LINES);
  localparam int TW = 30 - OW - IW;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    REFILL,
    RESP
  } state_t;

  state_t           state;
  logic             rdy_q;
  logic             kill_q;
  logic             inv_q;
  logic [29:0]      pc_q;
  logic [OW-1:0]    beat;
  logic [LINES-1:0] valid_q;
  logic [31:0]      resp_q;

  logic [TW-1:0] tag_ram [LINES];
  logic [31:0]   data_ram [LINES*WORDS_PER_LINE];
  logic [TW-1:0] tag_rd;
  logic [31:0]   data_rd;

  logic [IW-1:0] req_idx;
  logic [IW-1:0] cur_idx;
  logic [OW-1:0] req_off;
  logic [OW-1:0] cur_off;
  logic [TW-1:0] cur_tag;
  logic [31:0]   line_base;
  logic          hit;
  logic          accept;
  logic          last_beat;
  logic          fill_done;
  logic          unused_ok;

  assign req_off   = fe_addr[OW+1:2];
  assign req_idx   = fe_addr[OW+IW+1:OW+2];
  assign cur_off   = pc_q[OW-1:0];
  assign cur_idx   = pc_q[OW+IW-1:OW];
  assign cur_tag   = pc_q[29:OW+IW];
  assign unused_ok = ^fe_addr[1:0];

  // inv in the lookup cycle forces a miss
  assign hit = (state == LOOKUP) && valid_q[cur_idx]
            && (tag_rd == cur_tag) && !inv;

  assign fe_ready = rdy_q && ((state == IDLE) || hit);
  assign accept   = fe_req && fe_ready;
  assign fe_valid = (hit || (state == RESP)) && !fe_kill;
  assign fe_instr = !fe_valid ? '0
                  : (state == RESP) ? resp_q : data_rd;
  assign fe_pc    = fe_valid ? {pc_q, 2'b00} : '0;

  assign line_base = {pc_q[29:OW], {(OW+2){1'b0}}};
  assign mem_ren   = (state == REFILL);
  assign mem_addr  = mem_ren
                   ? line_base + {{(30-OW){1'b0}}, beat, 2'b00}
                   : '0;
  assign last_beat = &beat;
  assign fill_done = mem_ren && mem_done;

  always_ff @(posedge clk) begin
    if (accept) data_rd <= data_ram[{req_idx, req_off}];
    if (fill_done) data_ram[{cur_idx, beat}] <= mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (accept) tag_rd <= tag_ram[req_idx];
    if (fill_done && last_beat) tag_ram[cur_idx] <= cur_tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rdy_q      <= 1'b0;
      kill_q     <= 1'b0;
      inv_q      <= 1'b0;
      pc_q       <= '0;
      beat       <= '0;
      valid_q    <= '0;
      resp_q     <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (inv) valid_q <= '0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            pc_q  <= fe_addr[31:2];
            state <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (hit_count != '1) hit_count <= hit_count + 32'd1;
            if (accept) pc_q <= fe_addr[31:2];
            else state <= IDLE;
          end else begin
            if (miss_count != '1) miss_count <= miss_count + 32'd1;
            if (fe_kill) begin
              state <= IDLE;
            end else begin
              state  <= REFILL;
              beat   <= '0;
              kill_q <= 1'b0;
              inv_q  <= 1'b0;
            end
          end
        end
        REFILL: begin
          if (fe_kill) kill_q <= 1'b1;
          if (inv) inv_q <= 1'b1;
          if (mem_done) begin
            if (beat == cur_off) resp_q <= mem_rdata;
            beat <= beat + 1'b1;
            if (last_beat) begin
              // an invalidate seen during the fill leaves the line invalid
              if (!(inv || inv_q)) valid_q[cur_idx] <= 1'b1;
              state <= (kill_q || fe_kill) ? IDLE : RESP;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
